// File: rtl/bin_to_bcd3_seq_pkg.sv
// Shared types and constants for the signed binary to BCD converter.
package bin_to_bcd3_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAbs,
    StShift,
    StDone
  } state_e;

  localparam int unsigned BcdDigitW = 4;
  localparam logic [BcdDigitW-1:0] BcdNine   = 4'h9;
  localparam logic [BcdDigitW-1:0] AdjThresh = 4'd5;

  // Largest magnitude representable in `digits` decimal digits.
  function automatic int unsigned max_mag(int unsigned digits);
    int unsigned m;
    m = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      m = m * 10;
    end
    return m - 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd3_seq_if.sv
// Valid/ready bus between a producer of signed binary values and the BCD converter.
interface bin_to_bcd3_seq_if
  import bin_to_bcd3_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 3
);

  logic                          in_valid;
  logic                          in_ready;
  logic [BIN_W:0]                bin_in;
  logic                          out_valid;
  logic                          out_ready;
  logic                          bcd_sign;
  logic [BcdDigitW*DIGITS-1:0]   bcd_out;
  logic                          ovf;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_sign, bcd_out, ovf
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_sign, bcd_out, ovf
  );

endinterface

// File: rtl/bin_to_bcd3_seq_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bin_to_bcd3_seq_digit_adj
  import bin_to_bcd3_seq_pkg::*;
(
  input  logic [BcdDigitW-1:0] d_i,
  output logic [BcdDigitW-1:0] d_o
);

  assign d_o = (d_i >= AdjThresh) ? d_i + BcdDigitW'(3) : d_i;

endmodule

// File: rtl/bin_to_bcd3_seq.sv
// Sequential signed two's-complement to sign + BCD converter (shift-add-3).
// One conversion in flight; valid/ready on both sides.
module bin_to_bcd3_seq
  import bin_to_bcd3_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  bin_to_bcd3_seq_if.slave   bus_io
);

  localparam int unsigned MagW = BIN_W + 1;
  localparam int unsigned BcdW = BcdDigitW * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam logic [MagW-1:0] MaxMag = MagW'(max_mag(DIGITS));

  state_e            state_q, state_d;
  logic [MagW-1:0]   bin_q, bin_d;
  logic [BcdW-1:0]   scr_q, scr_d;
  logic [BIN_W-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              ovf_q, ovf_d;

  logic [MagW-1:0]   mag;
  logic [BcdW-1:0]   scr_adj;
  logic [BcdW-1:0]   scr_shl;
  logic [BIN_W-1:0]  shift_shl;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bin_to_bcd3_seq_digit_adj u_adj (
      .d_i (scr_q[g*BcdDigitW +: BcdDigitW]),
      .d_o (scr_adj[g*BcdDigitW +: BcdDigitW])
    );
  end

  // Magnitude is one bit wider than the value so the most negative input stays exact.
  assign mag = bin_q[BIN_W] ? (~bin_q + MagW'(1)) : bin_q;
  assign {scr_shl, shift_shl} = {scr_adj, shift_q} << 1;

  // Next-state and datapath: capture, absolute value, shift-add-3 loop, hold result.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          bin_d   = bus_io.bin_in;
          state_d = StAbs;
        end
      end
      StAbs: begin
        if (mag > MaxMag) begin
          sign_d  = bin_q[BIN_W];
          bcd_d   = {DIGITS{BcdNine}};
          ovf_d   = 1'b1;
          state_d = StDone;
        end else begin
          // mag fits in BIN_W bits here, so dropping the top bit is lossless.
          scr_d   = '0;
          shift_d = mag[BIN_W-1:0];
          cnt_d   = CntW'(BIN_W);
          state_d = StShift;
        end
      end
      StShift: begin
        scr_d   = scr_shl;
        shift_d = shift_shl;
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          sign_d  = bin_q[BIN_W];
          bcd_d   = scr_shl;
          ovf_d   = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bin_q   <= '0;
      scr_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus_io.in_ready  = (state_q == StIdle);
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.bcd_sign  = sign_q;
  assign bus_io.bcd_out   = bcd_q;
  assign bus_io.ovf       = ovf_q;

endmodule
